// File: rtl/cond_branch_unit.sv
// rtl/cond_branch_unit.sv - EX/MEM flag register, conditional branch resolution and taken-branch counter
//
// Purpose:
//   Sits after the ALU in EX. Holds the architectural NZCV flags, resolves
//   B.cond / CBZ / CBNZ and registers result, branch decision and valid into MEM.
//   Also keeps a saturating count of taken conditional branches.
//
// Ports:
//   clk, reset (async, active-low)
//   stall, flush                - pipeline control (stall has priority)
//   ex_valid, alu_result        - EX-stage instruction and its ALU result
//   alu_zero                    - result == 0, used by CBZ/CBNZ
//   write_flags, negative, zero_flag, carry, overflow - flag update from ALU
//   is_bcond, is_cbz, is_cbnz, cond - branch decode
//   mem_valid, mem_result, mem_branch_taken - MEM-stage registers
//   nzcv                        - architectural flags {N,Z,C,V}
//   taken_count                 - saturating taken-branch counter

module cond_branch_unit #(
  parameter int N     = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_zero,
  input  logic             write_flags,
  input  logic             zero_flag,
  input  logic             negative,
  input  logic             carry,
  input  logic             overflow,
  input  logic             is_bcond,
  input  logic             is_cbz,
  input  logic             is_cbnz,
  input  logic [3:0]       cond,
  output logic             mem_valid,
  output logic [N-1:0]     mem_result,
  output logic             mem_branch_taken,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] taken_count
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_true;
  logic taken;
  logic fire;
  logic is_branch;

  // B.cond sets no flags, so it is always evaluated against the registered
  // flags; a flag-setting op in the previous cycle is already visible here.
  assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = ~flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = ~flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = ~flag_v;
      4'b1000: cond_true = flag_c & ~flag_z;
      4'b1001: cond_true = ~flag_c | flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_true = flag_z | (flag_n != flag_v);
      default: cond_true = 1'b1;
    endcase
  end

  // Decode is nominally one-hot; if several strobes are set the terms simply OR.
  assign taken     = (is_bcond & cond_true) | (is_cbz & alu_zero) | (is_cbnz & ~alu_zero);
  assign is_branch = is_bcond | is_cbz | is_cbnz;
  assign fire      = ex_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid        <= 1'b0;
      mem_result       <= '0;
      mem_branch_taken <= 1'b0;
      nzcv             <= 4'b0000;
      taken_count      <= '0;
    end else if (!stall) begin
      if (flush) begin
        mem_valid        <= 1'b0;
        mem_branch_taken <= 1'b0;
        mem_result       <= '0;
      end else begin
        mem_valid        <= ex_valid;
        mem_result       <= alu_result;
        mem_branch_taken <= ex_valid & taken;
        // Bubbles may carry junk flag strobes; only real instructions write.
        if (fire && write_flags) begin
          nzcv <= {negative, zero_flag, carry, overflow};
        end
        if (fire && taken && is_branch && (taken_count != {CNT_W{1'b1}})) begin
          taken_count <= taken_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
// tb/tb_cond_branch_unit.sv - randomized and directed self-checking bench for cond_branch_unit

module tb_cond_branch_unit;

  localparam int N     = 64;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall, flush, ex_valid;
  logic [N-1:0]     alu_result;
  logic             alu_zero, write_flags;
  logic             zero_flag, negative, carry, overflow;
  logic             is_bcond, is_cbz, is_cbnz;
  logic [3:0]       cond;
  logic             mem_valid;
  logic [N-1:0]     mem_result;
  logic             mem_branch_taken;
  logic [3:0]       nzcv;
  logic [CNT_W-1:0] taken_count;

  cond_branch_unit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_result(alu_result), .alu_zero(alu_zero), .write_flags(write_flags),
    .zero_flag(zero_flag), .negative(negative), .carry(carry), .overflow(overflow),
    .is_bcond(is_bcond), .is_cbz(is_cbz), .is_cbnz(is_cbnz), .cond(cond),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_branch_taken(mem_branch_taken),
    .nzcv(nzcv), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic         m_valid;
  logic [N-1:0] m_result;
  logic         m_taken;
  logic [3:0]   m_nzcv;
  int           m_count;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Architectural rule: cond[3:1] picks a base predicate, cond[0] inverts it,
  // except 1111 which is also "always".
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_result = '0;
    m_taken  = 1'b0;
    m_nzcv   = 4'b0000;
    m_count  = 0;
  endtask

  task automatic model_step();
    logic tk;
    tk = (is_bcond && cond_holds(cond, m_nzcv)) || (is_cbz && alu_zero) || (is_cbnz && !alu_zero);
    if (stall) return;
    if (flush) begin
      m_valid  = 1'b0;
      m_taken  = 1'b0;
      m_result = '0;
      return;
    end
    m_valid  = ex_valid;
    m_result = alu_result;
    m_taken  = ex_valid && tk;
    if (ex_valid && write_flags) m_nzcv = {negative, zero_flag, carry, overflow};
    if (ex_valid && tk && m_count < CNT_MAX) m_count++;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".mem_valid"}, 64'(mem_valid), 64'(m_valid));
    check_eq({tag, ".mem_result"}, mem_result, m_result);
    check_eq({tag, ".mem_branch_taken"}, 64'(mem_branch_taken), 64'(m_taken));
    check_eq({tag, ".nzcv"}, 64'(nzcv), 64'(m_nzcv));
    check_eq({tag, ".taken_count"}, 64'(taken_count), 64'(m_count));
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; ex_valid = 0; alu_result = '0; alu_zero = 0;
    write_flags = 0; zero_flag = 0; negative = 0; carry = 0; overflow = 0;
    is_bcond = 0; is_cbz = 0; is_cbnz = 0; cond = 4'h0;
  endtask

  task automatic random_inputs();
    stall       = ($urandom % 8) == 0;
    flush       = ($urandom % 8) == 0;
    ex_valid    = ($urandom % 4) != 0;
    alu_result  = {$urandom, $urandom};
    alu_zero    = $urandom % 2;
    write_flags = ($urandom % 3) == 0;
    {negative, zero_flag, carry, overflow} = 4'($urandom);
    cond        = 4'($urandom);
    {is_bcond, is_cbz, is_cbnz} = 3'b000;
    case ($urandom % 8)
      0, 1, 2: is_bcond = 1;
      3:       is_cbz = 1;
      4:       is_cbnz = 1;
      5:       {is_bcond, is_cbz, is_cbnz} = 3'($urandom);
      default: ;
    endcase
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse taken between edges; checked before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1 reset = 0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    reset = 1;
  endtask

  task automatic bcond(input logic [3:0] c);
    idle_inputs();
    ex_valid = 1; is_bcond = 1; cond = c;
    alu_result = {$urandom, $urandom};
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 0;

    // reset held low while inputs toggle
    for (int i = 0; i < 4; i++) begin
      random_inputs();
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    @(negedge clk);
    idle_inputs();
    reset = 1;
    cycle("idle_after_reset");
    check_eq("idle.nzcv_zero", 64'(nzcv), 64'h0);

    // SUBS 5-5 then B.cond EQ
    @(negedge clk);
    idle_inputs();
    ex_valid = 1; write_flags = 1; zero_flag = 1; carry = 1; alu_result = '0; alu_zero = 1;
    cycle("subs_eq");
    check_eq("subs_eq.nzcv_const", 64'(nzcv), 64'h6);
    @(negedge clk);
    bcond(4'b0000);
    cycle("beq");
    check_eq("beq.taken_const", 64'(mem_branch_taken), 64'h1);
    check_eq("beq.count_const", 64'(taken_count), 64'h1);

    // SUBS 3-5 then LT (taken) then GE (not taken)
    @(negedge clk);
    idle_inputs();
    ex_valid = 1; write_flags = 1; negative = 1; alu_result = 64'hFFFF_FFFF_FFFF_FFFE;
    cycle("subs_lt");
    @(negedge clk);
    bcond(4'b1011);
    cycle("blt");
    check_eq("blt.taken_const", 64'(mem_branch_taken), 64'h1);
    @(negedge clk);
    bcond(4'b1010);
    cycle("bge");
    check_eq("bge.taken_const", 64'(mem_branch_taken), 64'h0);
    check_eq("bge.count_const", 64'(taken_count), 64'h2);

    // CBZ then CBNZ with alu_zero=1
    @(negedge clk);
    idle_inputs();
    ex_valid = 1; is_cbz = 1; alu_zero = 1;
    cycle("cbz");
    check_eq("cbz.taken_const", 64'(mem_branch_taken), 64'h1);
    @(negedge clk);
    is_cbz = 0; is_cbnz = 1;
    cycle("cbnz");
    check_eq("cbnz.taken_const", 64'(mem_branch_taken), 64'h0);
    check_eq("cbnz.nzcv_const", 64'(nzcv), 64'h8);

    // flushed ADDS, then stalled+flushed ADDS
    @(negedge clk);
    idle_inputs();
    ex_valid = 1; write_flags = 1; carry = 1; overflow = 1; flush = 1; alu_result = 64'h1234;
    cycle("adds_flush");
    check_eq("adds_flush.valid_const", 64'(mem_valid), 64'h0);
    @(negedge clk);
    flush = 0; is_cbz = 1; alu_zero = 1;
    cycle("cbz_before_stall");
    @(negedge clk);
    idle_inputs();
    ex_valid = 1; write_flags = 1; carry = 1; overflow = 1; stall = 1; flush = 1; alu_result = 64'h5678;
    cycle("adds_stall_flush");
    check_eq("adds_stall_flush.valid_hold", 64'(mem_valid), 64'h1);

    // reset asserted while stall and flush are high
    stall = 1; flush = 1;
    async_reset("reset_mid_stall");
    idle_inputs();

    // saturation: 17 taken B.cond AL on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bcond((i % 2 == 0) ? 4'hE : 4'hF);
      cycle("sat_al");
    end
    check_eq("sat.count_const", 64'(taken_count), 64'(CNT_MAX));

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) begin
        idle_inputs();
        async_reset("rand_reset");
      end
      @(negedge clk);
      random_inputs();
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
